xor_checksum_stream: RTL and testbench
======================================

// Module: xor_checksum_stream
// PURPOSE
//  Streaming, parametrised successor to the 2-input XOR gate: folds a frame of
//  WIDTH-bit words into a running XOR checksum under valid/ready flow control.
//  Reports the checksum and beat count once per frame.
//  Sits between a word source and a consumer as a frame-integrity generator/checker.
// PARAMETERS
//  WIDTH    8    data/checksum width in bits (>=1)
//  MAX_LEN  16   max counted beats per frame; beats beyond this set overflow
//  LEN_W    $clog2(MAX_LEN+1)  width of out_len (derived, not overridden)
// PORTS
//  clk        in   1        rising-edge clock
//  rst        in   1        synchronous reset, active-high
//  in_valid   in   1        input beat valid
//  in_ready   out  1        block can accept a beat
//  in_data    in   WIDTH    input word
//  in_last    in   1        marks final beat of frame
//  out_valid  out  1        frame result valid
//  out_ready  in   1        consumer accepts result
//  out_sum    out  WIDTH    XOR checksum of frame
//  out_len    out  LEN_W    beats counted in frame, saturating at MAX_LEN
//  out_ovf    out  1        frame exceeded MAX_LEN beats
//  out_err    out  1        checksum mismatch (XOR_CHK_EN only; else tied 0)
// BEHAVIOUR
//  - One clock (clk); reset synchronous, active-high (rst).
//  - Reset: state=ACCUM, acc=0, cnt=0, ovf=0, out_valid=0, out_sum=0,
//    out_len=0, out_ovf=0, out_err=0; in_ready=1 in the first cycle after reset.
//  - FSM ACCUM: in_ready=1. A beat is accepted when in_valid&in_ready.
//    - On each accepted beat: acc<=acc^in_data.
//    - cnt<=cnt+1 if cnt<MAX_LEN; else cnt holds and ovf<=1.
//    - Beat with in_last: final acc/cnt/ovf (including that beat) registered to
//      out_sum/out_len/out_ovf; out_valid=1 next cycle; go HOLD.
//  - FSM HOLD: in_ready=0. Outputs stable while out_valid&!out_ready.
//    - On out_ready: out_valid<=0, acc/cnt/ovf cleared, go ACCUM.
//    - Next beat accepted the following cycle.
//  - Latency: out_valid rises exactly 1 cycle after the last beat is accepted.
//  - Throughput: at least 1 dead input cycle per frame (the HOLD handshake cycle).
//  - in_valid without in_ready: no effect. in_data/in_last ignored unless accepted.
//  - Single-beat frame: out_sum=in_data, out_len=1.
//  - No simultaneous accept/emit: input is blocked in HOLD.
//  - rst mid-frame or in HOLD: partial frame and any pending result discarded;
//    all state returns to reset values.
//  - out_len is an unsigned count. out_sum is a pure bitwise XOR with no carries.
// CONFIGURATION
//  XOR_CHK_EN defined: check mode.
//    - The in_last beat carries the expected checksum and is not folded into out_sum.
//    - It is still counted in out_len.
//    - out_err=(acc_before_last != in_data_last), registered with out_valid.
//  XOR_CHK_EN undefined: generate mode.
//    - The last beat is folded like any other; out_err is constant 0.
// TESTING  (WIDTH=8, MAX_LEN=4)
//  1 Hold rst 2 cycles, release -> out_valid=0, in_ready=1, out_sum=0, out_len=0.
//  2 Beats 0x12,0x34,0x56(last), out_ready=1 -> 1 cyc later out_valid=1,
//    out_sum=0x70, out_len=3, out_ovf=0.
//  3 Frame 0xA5(last), out_ready=0 for 5 cycles -> out_valid/out_sum=0xA5/out_len=1
//    held, in_ready=0; after out_ready pulse, in_ready=1 next cycle.
//  4 Six beats 0x01..0x06, last on 0x06 -> out_sum=0x07, out_len=4, out_ovf=1;
//    next frame 0xFF(last) -> out_ovf=0, out_len=1.
//  5 Beats 0x11,0x22, then rst, then 0x0F(last) -> out_sum=0x0F, out_len=1.
//  6 XOR_CHK_EN: 0x12,0x34,0x26(last) -> out_sum=0x26, out_len=3, out_err=0;
//    same frame with last=0x27 -> out_err=1.

Source files
------------

// File: rtl/xor_checksum_stream.sv
// -----------------------------------------------------------------------------
// xor_checksum_stream
//
// Folds a frame of WIDTH-bit words into a running XOR checksum under
// valid/ready flow control. Once per frame it reports the checksum, the
// saturating beat count and an overflow flag.
//
// Build option:
//   XOR_CHK_EN  check mode. The in_last beat carries the expected checksum.
//               It is counted but not folded into the sum.
//               out_err flags a mismatch between the running sum and that word.
//   (undefined) generate mode. The last beat is folded like any other beat,
//               and out_err is tied to 0.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   in_valid   input beat valid
//   in_ready   block can accept a beat (high while accumulating)
//   in_data    input word
//   in_last    marks the final beat of a frame
//   out_valid  frame result valid (held until out_ready)
//   out_ready  consumer accepts the result
//   out_sum    XOR checksum of the frame
//   out_len    beats counted in the frame, saturating at MAX_LEN
//   out_ovf    frame exceeded MAX_LEN beats
//   out_err    checksum mismatch (check mode only)
// -----------------------------------------------------------------------------
module xor_checksum_stream #(
  parameter  int WIDTH   = 8,
  parameter  int MAX_LEN = 16,
  localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [LEN_W-1:0] out_len,
  output logic             out_ovf,
  output logic             out_err
);

  localparam logic [LEN_W-1:0] MAX_CNT = LEN_W'(MAX_LEN);

  typedef enum logic {
    ACCUM,  // accepting beats of the current frame
    HOLD    // presenting the frame result, input blocked
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] acc, acc_nxt;
  logic [LEN_W-1:0] cnt, cnt_nxt;
  logic             ovf, ovf_nxt;
  logic [WIDTH-1:0] result_sum;
  logic             accept;
  logic             capture;

  assign in_ready  = (state == ACCUM);
  // The result is valid for exactly the time spent in HOLD.
  assign out_valid = (state == HOLD);
  assign accept    = in_valid && in_ready;
  assign capture   = accept && in_last;

`ifdef XOR_CHK_EN
  logic result_err;
  logic out_err_q;

  // The last beat is the reference checksum, so the reported sum excludes it.
  assign result_sum = acc;
  assign result_err = (acc != in_data);
  assign out_err    = out_err_q;
`else
  assign result_sum = acc ^ in_data;
  assign out_err    = 1'b0;
`endif

  // NOTE: every signal driven here gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    ovf_nxt   = ovf;
    case (state)
      ACCUM: begin
        if (accept) begin
          acc_nxt = acc ^ in_data;
          if (cnt < MAX_CNT) begin
            cnt_nxt = cnt + LEN_W'(1);
          end else begin
            ovf_nxt = 1'b1;
          end
          if (in_last) begin
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        // The frame state is cleared at the handshake, so the next frame
        // starts from zero in the following cycle.
        if (out_ready) begin
          state_nxt = ACCUM;
          acc_nxt   = '0;
          cnt_nxt   = '0;
          ovf_nxt   = 1'b0;
        end
      end
      default: state_nxt = ACCUM;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then samples its inputs from before the edge, whatever the statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ACCUM;
      acc     <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
      out_sum <= '0;
      out_len <= '0;
      out_ovf <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      ovf   <= ovf_nxt;
      // The count and overflow flag include the last beat itself.
      if (capture) begin
        out_sum <= result_sum;
        out_len <= cnt_nxt;
        out_ovf <= ovf_nxt;
      end
    end
  end

`ifdef XOR_CHK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      out_err_q <= 1'b0;
    end else if (capture) begin
      out_err_q <= result_err;
    end
  end
`endif

endmodule

// File: tb/tb_xor_checksum_stream.sv
// -----------------------------------------------------------------------------
// tb_xor_checksum_stream
//
// Directed test of xor_checksum_stream with WIDTH=8 and MAX_LEN=4.
// The stimulus pushes hand-computed frame results into a scoreboard queue.
// A monitor pops one entry and compares it at every out_valid/out_ready
// handshake. Level checks on reset, hold and blocking are made inline.
// -----------------------------------------------------------------------------
module tb_xor_checksum_stream;

  localparam int WIDTH   = 8;
  localparam int MAX_LEN = 4;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic [LEN_W-1:0] len;
    logic             ovf;
    logic             err;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic [LEN_W-1:0] out_len;
  logic             out_ovf;
  logic             out_err;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  xor_checksum_stream #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_len   (out_len),
    .out_ovf   (out_ovf),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Monitor: compares the result at each handshake against the scoreboard.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result: got sum 0x%0h with an empty scoreboard at %0t",
                 out_sum, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_sum", 32'(out_sum), 32'(e.sum));
        check("out_len", 32'(out_len), 32'(e.len));
        check("out_ovf", 32'(out_ovf), 32'(e.ovf));
        check("out_err", 32'(out_err), 32'(e.err));
      end
    end
  end

  // Called just after a rising edge. Presents one beat and waits for
  // acceptance, with a bounded wait. Returns just after the accepting edge.
  task automatic send(input logic [WIDTH-1:0] d, input logic last);
    int waited = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(negedge clk);
    while (!in_ready && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      check("in_ready_timeout", 32'(in_ready), 32'd1);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'hXX;
    // out_valid must rise exactly one cycle after the last beat is accepted.
    if (last) begin
      @(negedge clk);
      check("latency_out_valid", 32'(out_valid), 32'd1);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_frame(input logic [WIDTH-1:0] s, input logic [LEN_W-1:0] l,
                              input logic o, input logic e);
    exp_t x;
    x.sum = s;
    x.len = l;
    x.ovf = o;
    x.err = e;
    sb.push_back(x);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Watchdog: makes sure the run always reaches the summary line.
  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;

    // 1: reset held for two cycles
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_sum",   32'(out_sum),   32'd0);
    check("rst_out_len",   32'(out_len),   32'd0);
    check("rst_out_ovf",   32'(out_ovf),   32'd0);
    check("rst_out_err",   32'(out_err),   32'd0);
    @(posedge clk);
    #1;

    // 2: three-beat frame, 0x12^0x34^0x56 = 0x70
    expect_frame(8'h70, 3'd1 + 3'd2, 1'b0, 1'b0);
    send(8'h12, 1'b0);
    send(8'h34, 1'b0);
    send(8'h56, 1'b1);

    // 3: single-beat frame held under back-pressure
    out_ready = 1'b0;
    expect_frame(8'hA5, 3'd1, 1'b0, 1'b0);
    send(8'hA5, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_out_sum",   32'(out_sum),   32'hA5);
      check("hold_out_len",   32'(out_len),   32'd1);
      check("hold_in_ready",  32'(in_ready),  32'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("release_in_ready",  32'(in_ready),  32'd1);
    check("release_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;

    // 4: six beats into MAX_LEN=4. XOR of 1..6 is 0x07, len saturates, ovf set.
    expect_frame(8'h07, 3'd4, 1'b1, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      send(8'(i), (i == 6));
    end
    // Overflow must not leak into the following frame.
    expect_frame(8'hFF, 3'd1, 1'b0, 1'b0);
    send(8'hFF, 1'b1);

    // 5: reset mid-frame discards the partial frame
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    pulse_reset();
    @(negedge clk);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready",  32'(in_ready),  32'd1);
    @(posedge clk);
    #1;
    expect_frame(8'h0F, 3'd1, 1'b0, 1'b0);
    send(8'h0F, 1'b1);

    // Reset while a result is pending discards that result.
    out_ready = 1'b0;
    send(8'h99, 1'b1);
    pulse_reset();
    @(negedge clk);
    check("holdrst_out_valid", 32'(out_valid), 32'd0);
    check("holdrst_out_sum",   32'(out_sum),   32'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;

    // 6: check-mode vectors. In generate mode the last beat is folded in.
`ifdef XOR_CHK_EN
    expect_frame(8'h26, 3'd3, 1'b0, 1'b0);
`else
    expect_frame(8'h00, 3'd3, 1'b0, 1'b0);
`endif
    send(8'h12, 1'b0);
    send(8'h34, 1'b0);
    send(8'h26, 1'b1);
`ifdef XOR_CHK_EN
    expect_frame(8'h26, 3'd3, 1'b0, 1'b1);
`else
    expect_frame(8'h01, 3'd3, 1'b0, 1'b0);
`endif
    send(8'h12, 1'b0);
    send(8'h34, 1'b0);
    send(8'h27, 1'b1);

    repeat (4) @(posedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
